audio_sample_feeder: RTL and testbench
======================================

Name: audio_sample_feeder

Overview:
- Downstream stage of the synth tone generators. Samples the 32-bit generator output at the audio sample rate and applies a right-shift volume attenuation.
- Buffers the samples in a small FIFO and pushes them to the audio codec core through its write/allowed handshake.
- Drives the left and right channels with identical mono data.

Parameters:
- CLOCK_FREQUENCY, 50000000, system clock in Hz.
- SAMPLE_RATE, 48000, output sample rate in Hz. DIV = CLOCK_FREQUENCY / SAMPLE_RATE, integer-truncated (1041 at defaults).
- FIFO_DEPTH, 8, buffer entries; must be a power of two, at least 2.
- DATA_W, 32, sample width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  sampling enable; the drain side runs regardless.
- sample_in  in  DATA_W  generator output (unsigned, 0..2*amplitude).
- volume_shift  in  3  attenuation; sample is logically right-shifted by 0..7.
- clear_overflow  in  1  one-cycle pulse that clears overflow.
- audio_out_allowed  in  1  codec FIFO has space.
- write_audio_out  out  1  one-cycle write strobe to the codec.
- left_channel_audio_out  out  DATA_W  sample to the codec.
- right_channel_audio_out  out  DATA_W  same value as left.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a sample was dropped.

Behaviour:
- One clock, clk. Asynchronous active-low reset reset_n.
- Reset (any time, including mid-transfer):
  - tick counter = DIV-1; FIFO empty; fifo_level = 0.
  - write_audio_out = 0; both channel outputs = 0; overflow = 0.
- Tick counter:
  - Counts down when enable = 1. At 0 it asserts tick for that cycle and reloads DIV-1, so there is one tick per DIV cycles.
  - When enable = 0 it is held at DIV-1 and no tick occurs.
  - When enable rises, the first tick comes DIV cycles later.
- Push: on a tick cycle, sample_in >> volume_shift (zero fill, values sampled that cycle) is written at the next edge.
- Pop:
  - do_pop = (level != 0) & audio_out_allowed, evaluated combinationally each cycle.
  - On do_pop, the head word is registered into both channel outputs, write_audio_out = 1 next cycle, and the read pointer advances.
  - Otherwise write_audio_out = 0 next cycle and the channel outputs hold their last value.
- Write strobe: write_audio_out is never high two cycles in a row unless a pop was issued in each cycle. The codec consumes data on every high cycle.
- Full:
  - A push is accepted if level < FIFO_DEPTH, or if do_pop is asserted in the same cycle (simultaneous push and pop).
  - Otherwise the sample is dropped, the FIFO is unchanged, and overflow is set.
- Empty: no pop, and write_audio_out stays 0.
- Simultaneous push and pop: the level is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Latency: a tick in cycle T into an empty FIFO with allowed = 1 gives write_audio_out high in cycle T+2, carrying that sample.
- Overflow flag:
  - Cleared by clear_overflow.
  - If a drop and clear_overflow occur in the same cycle, the set wins.
- audio_out_allowed falling mid-stream: no further strobes; the FIFO retains its data.

Decomposition:
- Shared package synth_pkg:
  - CLOCK_FREQUENCY constant.
  - SAMPLE_W = 32.
  - Default SAMPLE_RATE.
  - sample_t typedef (logic [31:0]).
- One natural sub-module: sync_fifo (parameterised DEPTH/WIDTH).
  - Ports: push, pop, din, dout (head, read combinationally), level, full, empty; asynchronous active-low reset.
  - audio_sample_feeder holds the tick counter, shift, pop logic, output registers and overflow flag.

Test Plan:
- Reset and tick period.
  - Stimulus: CLOCK_FREQUENCY=100, SAMPLE_RATE=10 (DIV = 10); enable = 1; allowed = 1; sample_in = 32'h0000_1000; shift = 0.
  - Response: write_audio_out pulses every 10 cycles, with both channels = 32'h1000. The first pulse arrives 2 cycles after the first tick.
- Volume shift.
  - Stimulus: sample_in = 32'hFFFF_FFFF, shift = 7.
  - Response: channels = 32'h01FF_FFFF.
- Back-pressure and overflow.
  - Stimulus: allowed = 0 for 9 ticks, FIFO_DEPTH = 8.
  - Response: level saturates at 8; overflow = 1 after the 9th tick. When allowed rises, there are 8 consecutive strobes delivering the first 8 samples in order, and the 9th sample is absent.
- Full with simultaneous pop.
  - Stimulus: level = 8, allowed rises in the tick cycle.
  - Response: the sample is accepted, level stays 8, overflow stays 0.
- Overflow clear race.
  - Stimulus: clear_overflow pulse on the same cycle as a dropped sample.
  - Response: overflow remains 1.
  - Stimulus: a later clear with no drop.
  - Response: overflow = 0.
- Reset mid-operation and enable gating.
  - Stimulus: assert reset_n = 0 asynchronously mid-cycle with level = 5.
  - Response: immediately level = 0, write_audio_out = 0, channels = 0.
  - Stimulus: release reset with enable = 0 for 50 cycles.
  - Response: no strobes. With enable = 1, the first tick comes 10 cycles later.

Source files
------------

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : synth_pkg
//  Description : Constants and types shared by the synth audio path.
//                CLOCK_FREQUENCY : system clock in Hz
//                SAMPLE_RATE     : default audio sample rate in Hz
//                SAMPLE_W        : generator sample width
//                sample_t        : one generator sample
//  Revision    : 1.0  initial release
// ============================================================================
package synth_pkg;

    localparam int CLOCK_FREQUENCY = 50_000_000;
    localparam int SAMPLE_RATE     = 48_000;
    localparam int SAMPLE_W        = 32;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Clock cycles per output sample, truncated toward zero.
    function automatic int sample_divider(input int clock_hz, input int rate_hz);
        return clock_hz / rate_hz;
    endfunction

endpackage : synth_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with a combinationally readable head word.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset (empties the FIFO)
//                push   - write din at the next edge
//                pop    - drop the head word at the next edge
//                din    - write data
//                dout   - current head word (only meaningful when !empty)
//                level  - current occupancy, 0..DEPTH
//                full   - level == DEPTH
//                empty  - level == 0
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int                 c_ptr_w      = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_full_level = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_lvl_one    = (c_ptr_w + 1)'(1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]   level_q, level_d;
    logic               wr_en;
    logic               rd_en;

    always_comb begin
        empty = (level_q == '0);
        full  = (level_q == c_full_level);
        // A pop frees a slot in the same cycle, so a full FIFO still takes
        // a write when it is being read.
        rd_en = pop && !empty;
        wr_en = push && (!full || rd_en);

        // DEPTH is a power of two, so the pointers wrap on their own.
        wr_ptr_d = wr_en ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d = rd_en ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;

        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + c_lvl_one;
            2'b01:   level_d = level_q - c_lvl_one;
            default: level_d = level_q;
        endcase

        dout  = mem_q[rd_ptr_q];
        level = level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/audio_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sample_feeder
//  Description : Samples the tone generator output once per sample period,
//                applies a right-shift volume attenuation, buffers the result
//                and hands it to the audio codec core as identical left and
//                right samples through the write/allowed handshake.
//  Ports       : clk                     - system clock
//                reset_n                 - asynchronous active-low reset
//                enable                  - sampling enable (drain always runs)
//                sample_in               - generator output, unsigned
//                volume_shift            - logical right shift 0..7
//                clear_overflow          - pulse, clears overflow
//                audio_out_allowed       - codec has room for a sample
//                write_audio_out         - one-cycle write strobe to codec
//                left_channel_audio_out  - sample to codec
//                right_channel_audio_out - same value as left
//                fifo_level              - buffer occupancy
//                overflow                - sticky, a sample was dropped
//  Revision    : 1.0  initial release
// ============================================================================
module audio_sample_feeder #(
    parameter int CLOCK_FREQUENCY = synth_pkg::CLOCK_FREQUENCY,
    parameter int SAMPLE_RATE     = synth_pkg::SAMPLE_RATE,
    parameter int FIFO_DEPTH      = 8,
    parameter int DATA_W          = synth_pkg::SAMPLE_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             sample_in,
    input  logic [2:0]                    volume_shift,
    input  logic                          clear_overflow,
    input  logic                          audio_out_allowed,
    output logic                          write_audio_out,
    output logic [DATA_W-1:0]             left_channel_audio_out,
    output logic [DATA_W-1:0]             right_channel_audio_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    import synth_pkg::*;

    localparam int                 c_div    = sample_divider(CLOCK_FREQUENCY, SAMPLE_RATE);
    localparam int                 c_cnt_w  = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(c_div - 1);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
    localparam int                 c_lvl_w  = $clog2(FIFO_DEPTH) + 1;

    // Sample-rate tick
    logic [c_cnt_w-1:0] tick_cnt_q, tick_cnt_d;
    logic               tick;

    // Buffer interface
    logic [DATA_W-1:0]  shifted;
    logic               fifo_push;
    logic               do_pop;
    logic               drop;
    logic [DATA_W-1:0]  fifo_dout;
    logic [c_lvl_w-1:0] fifo_lvl;
    logic               fifo_full;
    logic               fifo_empty;

    // Output registers
    logic               wr_q, wr_d;
    logic [DATA_W-1:0]  chan_q, chan_d;
    logic               ovf_q, ovf_d;

    always_comb begin
        // Counter parks at DIV-1 while disabled, so the first tick after
        // enable rises is a full sample period later.
        tick = enable && (tick_cnt_q == '0);
        if (!enable || tick) begin
            tick_cnt_d = c_reload;
        end else begin
            tick_cnt_d = tick_cnt_q - c_one;
        end

        shifted = sample_in >> volume_shift;

        do_pop    = !fifo_empty && audio_out_allowed;
        fifo_push = tick && (!fifo_full || do_pop);
        drop      = tick && fifo_full && !do_pop;

        // The strobe follows the pop by one cycle; data holds otherwise.
        wr_d   = do_pop;
        chan_d = do_pop ? fifo_dout : chan_q;

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = drop | (ovf_q & ~clear_overflow);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= c_reload;
            wr_q       <= 1'b0;
            chan_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            wr_q       <= wr_d;
            chan_q     <= chan_d;
            ovf_q      <= ovf_d;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (do_pop),
        .din   (shifted),
        .dout  (fifo_dout),
        .level (fifo_lvl),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign write_audio_out         = wr_q;
    assign left_channel_audio_out  = chan_q;
    assign right_channel_audio_out = chan_q;
    assign fifo_level              = fifo_lvl;
    assign overflow                = ovf_q;

endmodule : audio_sample_feeder
`default_nettype wire

// File: tb/tb_audio_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_sample_feeder
//  Description : Self-checking bench for audio_sample_feeder. A queue-based
//                reference model predicts strobe, channel data, level and
//                overflow every cycle; directed phases cover the sample
//                period, volume shift, back-pressure, full-with-pop, the
//                overflow clear race and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_sample_feeder;

    localparam int CLK_F = 100;
    localparam int RATE  = 10;
    localparam int DIV   = CLK_F / RATE;
    localparam int DEPTH = 8;
    localparam int DW    = 32;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      enable;
    logic [DW-1:0]             sample_in;
    logic [2:0]                volume_shift;
    logic                      clear_overflow;
    logic                      audio_out_allowed;
    logic                      write_audio_out;
    logic [DW-1:0]             left_channel_audio_out;
    logic [DW-1:0]             right_channel_audio_out;
    logic [$clog2(DEPTH):0]    fifo_level;
    logic                      overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic          m_wr;
    logic [DW-1:0] m_chan;
    logic          m_ovf;
    int            m_run;

    audio_sample_feeder #(
        .CLOCK_FREQUENCY (CLK_F),
        .SAMPLE_RATE     (RATE),
        .FIFO_DEPTH      (DEPTH),
        .DATA_W          (DW)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .enable                  (enable),
        .sample_in               (sample_in),
        .volume_shift            (volume_shift),
        .clear_overflow          (clear_overflow),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .fifo_level              (fifo_level),
        .overflow                (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_q.delete();
        m_wr   = 1'b0;
        m_chan = '0;
        m_ovf  = 1'b0;
        m_run  = 0;
    endtask

    // True when the cycle about to be clocked is a sample tick: the DIV-th,
    // 2*DIV-th, ... consecutive enabled cycle.
    function automatic bit will_tick();
        return enable && (((m_run + 1) % DIV) == 0);
    endfunction

    task automatic compare_all();
        check("wr",    32'(write_audio_out),   32'(m_wr));
        check("left",  left_channel_audio_out,  m_chan);
        check("right", right_channel_audio_out, m_chan);
        check("level", 32'(fifo_level),         32'(m_q.size()));
        check("ovf",   32'(overflow),           32'(m_ovf));
    endtask

    // Advance one clock: predict from the inputs now applied, clock, compare.
    task automatic step();
        bit t;
        bit p;
        bit d;
        if (!reset_n) begin
            m_reset();
        end else begin
            t = will_tick();
            p = (m_q.size() != 0) && audio_out_allowed;
            d = 1'b0;
            if (p) begin
                m_chan = m_q.pop_front();
                m_wr   = 1'b1;
            end else begin
                m_wr   = 1'b0;
            end
            if (t) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back(sample_in >> volume_shift);
                end else begin
                    d = 1'b1;
                end
            end
            m_ovf = d | (m_ovf & ~clear_overflow);
            m_run = enable ? m_run + 1 : 0;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [DW-1:0] exp_list[$];
        int            ticks;
        int            n;
        int            first;
        int            last;
        int            mode;

        reset_n           = 1'b1;
        enable            = 1'b0;
        sample_in         = '0;
        volume_shift      = '0;
        clear_overflow    = 1'b0;
        audio_out_allowed = 1'b0;
        m_reset();
        #1 reset_n = 1'b0;
        #11;
        check("rst_wr",    32'(write_audio_out),    32'd0);
        check("rst_left",  left_channel_audio_out,  32'd0);
        check("rst_right", right_channel_audio_out, 32'd0);
        check("rst_level", 32'(fifo_level),         32'd0);
        check("rst_ovf",   32'(overflow),           32'd0);
        @(posedge clk);
        #1;

        // Sample period: first strobe DIV+1 steps after enable, then every DIV.
        reset_n           = 1'b1;
        enable            = 1'b1;
        audio_out_allowed = 1'b1;
        sample_in         = 32'h0000_1000;
        first             = -1;
        last              = -1;
        for (int i = 1; i <= 5 * DIV; i++) begin
            step();
            if (write_audio_out) begin
                if (first < 0) first = i;
                else check("period", 32'(i - last), 32'(DIV));
                last = i;
                check("period_data", left_channel_audio_out, 32'h0000_1000);
            end
        end
        check("first_strobe", 32'(first), 32'(DIV + 1));

        // Volume shift
        sample_in    = 32'hFFFF_FFFF;
        volume_shift = 3'd7;
        for (int i = 0; i < 2 * DIV; i++) step();
        check("shift7", left_channel_audio_out, 32'h01FF_FFFF);

        // Drain and start from an empty FIFO with overflow clear
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Back-pressure for nine ticks; clear races the ninth (dropped) one.
        enable            = 1'b1;
        audio_out_allowed = 1'b0;
        ticks             = 0;
        for (int i = 0; i < 12 * DIV && ticks < 9; i++) begin
            sample_in    = $urandom;
            volume_shift = 3'($urandom_range(0, 7));
            if (will_tick()) begin
                ticks++;
                exp_list.push_back(sample_in >> volume_shift);
                if (ticks == 9) clear_overflow = 1'b1;
            end
            step();
            clear_overflow = 1'b0;
        end
        check("sat_level", 32'(fifo_level), 32'd8);
        check("ovf_race",  32'(overflow),   32'd1);

        // A clear with no drop
        enable         = 1'b0;
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        check("ovf_clear", 32'(overflow), 32'd0);

        // Release back-pressure: eight consecutive strobes, ninth sample gone.
        audio_out_allowed = 1'b1;
        n                 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (write_audio_out) begin
                if (n < 9) check("drain_data", left_channel_audio_out, exp_list[n]);
                if (i >= 8) check("drain_consec", 32'(i), 32'd7);
                n++;
            end
        end
        check("drain_count", 32'(n), 32'd8);

        // Full FIFO, allowed rises in the tick cycle: sample accepted.
        enable            = 1'b1;
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 12 * DIV && m_q.size() < DEPTH; i++) begin
            sample_in = $urandom;
            step();
        end
        for (int i = 0; i < DIV && !will_tick(); i++) step();
        audio_out_allowed = 1'b1;
        step();
        audio_out_allowed = 1'b0;
        check("fullpop_level", 32'(fifo_level), 32'd8);
        check("fullpop_ovf",   32'(overflow),   32'd0);

        // Randomized operation with bursty back-pressure
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) mode = int'($urandom_range(0, 2));
            sample_in         = $urandom;
            volume_shift      = 3'($urandom_range(0, 7));
            enable            = ($urandom_range(0, 49) != 0);
            clear_overflow    = ($urandom_range(0, 29) == 0);
            audio_out_allowed = (mode == 0) ? 1'b0 :
                                (mode == 1) ? 1'($urandom_range(0, 1)) :
                                              ($urandom_range(0, 9) != 0);
            step();
        end
        clear_overflow = 1'b0;

        // Asynchronous reset mid-cycle with five samples buffered
        audio_out_allowed = 1'b1;
        enable            = 1'b0;
        for (int i = 0; i < 4; i++) step();
        enable            = 1'b1;
        audio_out_allowed = 1'b0;
        for (int i = 0; i < 12 * DIV && m_q.size() < 5; i++) begin
            sample_in = $urandom;
            step();
        end
        check("pre_rst_level", 32'(fifo_level), 32'd5);
        #2 reset_n = 1'b0;
        #1;
        check("arst_level", 32'(fifo_level),         32'd0);
        check("arst_wr",    32'(write_audio_out),    32'd0);
        check("arst_left",  left_channel_audio_out,  32'd0);
        check("arst_right", right_channel_audio_out, 32'd0);
        m_reset();
        step();

        reset_n           = 1'b1;
        enable            = 1'b0;
        audio_out_allowed = 1'b1;
        n                 = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (write_audio_out) n++;
        end
        check("gated_strobes", 32'(n), 32'd0);

        enable = 1'b1;
        first  = -1;
        for (int i = 1; i <= 3 * DIV && first < 0; i++) begin
            step();
            if (write_audio_out) first = i;
        end
        check("reen_first", 32'(first), 32'(DIV + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_audio_sample_feeder
`default_nettype wire
